// File: rtl/priority_encoder8to3.sv
// -----------------------------------------------------------------------------
// priority_encoder8to3
//
// Registered 8-to-3 priority encoder with sticky request capture and a
// valid/ack handshake. Request pulses are latched into a pending vector and
// held until the consumer accepts the code that selected them, so a
// single-cycle pulse is never lost.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous active-low reset
//   req    in   8  request lines; a high bit marks that request pending
//   mask   in   8  a high bit blocks selection of that request (it stays pending)
//   ack    in   1  consumer accepts the presented code (only while valid=1)
//   code   out  3  index of the selected request
//   valid  out  1  code is being presented
//   pend   out  8  registered pending vector
//   any    out  1  registered OR of the pending vector
//
// Configuration:
//   PRIORITY_ENC_ROUND_ROBIN_EN  when defined, a 3-bit pointer remembers the
//                                last accepted index and the search order
//                                becomes last-1, last-2, ... mod 8, ending at
//                                last. When undefined, fixed priority with
//                                bit 7 highest and bit 0 lowest.
// -----------------------------------------------------------------------------
module priority_encoder8to3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pend,
  output logic       any
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_code;
  logic [7:0] r_pend;
  logic       r_any;

  logic       w_accept;
  logic [7:0] w_clr;
  logic [7:0] w_pend_next;
  logic [7:0] w_elig;
  logic       w_hit;
  logic [2:0] w_sel;

`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
  logic [2:0] r_last;
  logic [2:0] w_ptr;
`endif

  // An ack only counts while a code is actually presented; a stray ack in
  // IDLE must not clear anything.
  assign w_accept = (r_state == S_PRESENT) && ack;

  assign w_clr = w_accept ? (8'b0000_0001 << r_code) : 8'h00;

  // Clear first, then OR in new requests: a request arriving on the bit being
  // accepted in the same cycle keeps that bit pending (set wins).
  assign w_pend_next = (r_pend & ~w_clr) | req;

  // Eligibility looks at the post-clear/post-set vector and today's mask, so
  // a back-to-back load on accept already excludes the code just retired.
  assign w_elig = w_pend_next & ~mask;

`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
  // On an accept the pointer is being updated to the accepted code this very
  // edge; use that value so the back-to-back search already starts after it.
  assign w_ptr = w_accept ? r_code : r_last;

  // Search order is ptr-1, ptr-2, ..., ptr (k = 1..8, wrapping mod 8).
  // Walking k downward and letting the last hit win leaves the smallest k,
  // i.e. the highest-priority candidate, in w_sel.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise a path that skips the assignment infers a latch.
    w_hit = 1'b0;
    w_sel = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (w_elig[3'(w_ptr - 3'(k))]) begin
        w_hit = 1'b1;
        w_sel = 3'(w_ptr - 3'(k));
      end
    end
  end
`else
  // Fixed priority, bit 7 highest: scan upward and let the last hit win.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise a path that skips the assignment infers a latch.
    w_hit = 1'b0;
    w_sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_elig[i]) begin
        w_hit = 1'b1;
        w_sel = 3'(i);
      end
    end
  end
`endif

  // Single FSM block; all outputs come straight from registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_code  <= 3'd0;
      r_pend  <= 8'h00;
      r_any   <= 1'b0;
`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
      r_last  <= 3'd0;
`endif
    end else begin
      r_pend <= w_pend_next;
      r_any  <= |w_pend_next;
`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
      if (w_accept) begin
        r_last <= r_code;
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_code  <= w_sel;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // Without ack the code is held even if the mask now covers it.
          if (ack) begin
            if (w_hit) begin
              r_code <= w_sel;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign code  = r_code;
  assign valid = (r_state == S_PRESENT);
  assign pend  = r_pend;
  assign any   = r_any;

endmodule

// File: doc/priority_encoder8to3.md
# priority_encoder8to3

Registered 8-to-3 priority encoder with sticky pending capture and a valid/ack handshake. It is the inverse of the CPU's 3-to-8 decoder: it turns up to eight one-hot or multi-hot request lines into one 3-bit index. It sits between peripheral request/interrupt lines and the control unit. Each request is held until the consumer accepts its code, so a one-cycle pulse is never lost.

## Interface
- No parameters; width fixed at 8 requests / 3-bit code.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset (sampled on `clk` rising edge).
- `req` input 8: request lines; bit i high for ≥1 cycle marks request i pending.
- `mask` input 8: bit i high blocks selection of request i; the request stays pending.
- `ack` input 1: consumer accepts the presented code; meaningful only while `valid`=1.
- `code` output 3: index of the selected request.
- `valid` output 1: `code` is presented.
- `pend` output 8: registered pending vector.
- `any` output 1: `|pend`, registered.

## Operation
- Pending register: `pend_next = (pend & ~clr) | req`.
  - `clr` is one-hot at `code` when `valid & ack`, else 0.
  - Set wins: if a request arrives on the bit being cleared in the same cycle, the bit stays pending.
- Eligible vector: `elig = pend_next & ~mask`, using the current-cycle `mask`.
- FSM, two states:
  - IDLE (`valid`=0): if `elig`≠0, load `code` = highest-priority bit of `elig`, go to PRESENT. Otherwise stay.
  - PRESENT (`valid`=1, `ack`=0): hold `code`. `mask` changes do not withdraw the presented code.
  - PRESENT with `ack`=1: clear bit `code`. If `elig`≠0 (computed after the clear), load the next `code` and stay in PRESENT (back-to-back). Otherwise go to IDLE.
- Fixed priority: bit 7 highest, bit 0 lowest.
- `ack` while `valid`=0 is ignored and causes no clear.
- Reset: `pend`=8'h00, `code`=3'd0, `valid`=0, `any`=0, FSM=IDLE, rotation pointer=3'd0. Reset overrides `req` and `ack` in the same cycle, including mid-handshake.

## Timing
- Latency 1: `req` bit high at edge E (unmasked, FSM idle) gives `valid`=1 and `code` set right after E.
- `pend` and `any` reflect the same-edge `req`, so they are valid after E.
- Throughput is one code per cycle while `ack` is held high and eligible requests remain.
- `code` is stable from the `valid` rise until the edge where `ack`=1.
- A request masked at its arrival edge becomes eligible on the first edge after `mask` drops, and is presented after that edge.

## Configuration
- `PRIORITY_ENC_ROUND_ROBIN_EN` defined:
  - A 3-bit pointer `last` records the granted index at each accept.
  - Search order is `last-1, last-2, …` mod 8, ending at `last`.
  - With reset pointer 0 the order is 7,6,…,0, matching fixed priority until the first grant.
- Undefined: fixed priority 7→0; no pointer is implemented.

## Test plan
- Reset: drive `req`=8'hFF, `rst_n`=0 for 2 cycles → `valid`=0, `code`=0, `pend`=8'h00, `any`=0. Release reset with `req`=0 → outputs unchanged.
- Single pulse: one-cycle `req`=8'h10 with `ack`=0 → `valid`=1 and `code`=4 the next cycle, held 5 cycles. `ack`=1 for one cycle → `valid`=0 and `pend`=8'h00 the next cycle.
- Multi-hot, fixed priority: `req`=8'hA5 pulse, `ack` held high → codes 7,5,2,0 on consecutive cycles, then `valid`=0. With `PRIORITY_ENC_ROUND_ROBIN_EN`, the same stimulus gives 7,5,2,0. Then a pulse of 8'hA5 with last=0 gives 7,5,2,0 again, while `req`=8'h81 after granting 7 gives 0 before 7.
- Set-wins collision: `code`=3 presented; in the `ack` cycle also drive `req`=8'h08 → `pend[3]`=1, and `code`=3 is presented again the next cycle.
- Mask: `mask`=8'h80 with `req`=8'h81 pulse → `code`=0 first. After accept, `valid`=0 with `pend`=8'h80. Drop `mask` → `code`=7 one cycle later.
- Reset mid-handshake: `valid`=1, `code`=6, `pend`=8'h42; assert `rst_n`=0 together with `ack`=1 → all outputs at reset values the next cycle.
